// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type, default sizes and channel-index width helper
// for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;

    localparam int PWM_WIDTH_DEF    = 8;
    localparam int PWM_CHANNELS_DEF = 2;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one compare channel with duty registers and a registered output.
// PWM_SYNC_DUTY_EN adds the shadow stage loaded into the active duty on load_i.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] act_q, act_d;
    logic             pwm_q;

`ifdef PWM_SYNC_DUTY_EN
    logic [WIDTH-1:0] shd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shd_q <= '0;
        else if (wr_i) shd_q <= duty_i;
    end

    // the shadow value before this edge's write is the one transferred
    assign act_d = load_i ? shd_q : act_q;
`else
    logic unused_load;

    assign unused_load = load_i;
    assign act_d       = wr_i ? duty_i : act_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            act_q <= act_d;
            pwm_q <= en_i & (cnt_i < act_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_chan.sv
// pwm_multi_chan: shared edge/center-aligned period counter driving CHANNELS
// compare channels. Define PWM_SYNC_DUTY_EN for period-boundary duty/mode updates.
module pwm_multi_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int CHANNELS = PWM_CHANNELS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           mode,
    input  logic                           wr,
    input  logic [chan_bits(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]               wr_duty,
    output logic [CHANNELS-1:0]            PWM_sig,
    output logic                           prd_strt
);

    localparam int               CW  = chan_bits(CHANNELS);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dn_q, dn_d;
    logic             prd_q, prd_d;
    logic             center, bnd;
    pwm_mode_t        cur_mode;

`ifdef PWM_SYNC_DUTY_EN
    pwm_mode_t mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= PWM_EDGE;
        else if (!en || bnd) mode_q <= pwm_mode_t'(mode);
    end

    assign cur_mode = mode_q;
`else
    assign cur_mode = pwm_mode_t'(mode);
`endif

    always_comb begin
        center = (cur_mode == PWM_CENTER);
        bnd    = en & (center ? (dn_q & (cnt_q == ONE)) : (cnt_q == MAX));
        // center mode turns around at MAX and keeps descending down to 0
        cnt_d  = !en ? '0 : (center && (dn_q || cnt_q == MAX)) ? cnt_q - ONE : cnt_q + ONE;
        dn_d   = en & center & (dn_q ? (cnt_q != ONE) : (cnt_q == MAX));
        prd_d  = en & (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dn_q  <= 1'b0;
            prd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dn_q  <= dn_d;
            prd_q <= prd_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .load_i (~en | bnd),
            .wr_i   (wr && (wr_ch == CW'(c))),
            .duty_i (wr_duty),
            .cnt_i  (cnt_q),
            .pwm_o  (PWM_sig[c])
        );
    end

    assign prd_strt = prd_q;

endmodule

// File: doc/pwm_multi_chan.md
# pwm_multi_chan

Parametrised multi-channel PWM generator for the motor-drive path. A single shared period counter drives CHANNELS independent compare channels of WIDTH-bit resolution, in edge-aligned or center-aligned mode. Each channel has a registered, glitch-free output. Duty writes are double-buffered so that a new duty takes effect only at a period boundary. The block replaces the fixed 8-bit single-channel PWM in the drive datapath and is written by the motor controller.

## Interface
- WIDTH, 8: counter and duty resolution in bits (≥2).
- CHANNELS, 2: number of PWM outputs (≥1).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  run enable; low holds counter at 0 and forces all outputs low.
- mode  in  1  0 = edge-aligned, 1 = center-aligned.
- wr  in  1  duty write strobe, one channel per cycle.
- wr_ch  in  $clog2(CHANNELS) (min 1)  target channel of write.
- wr_duty  in  WIDTH  duty value written.
- PWM_sig  out  CHANNELS  per-channel PWM output, registered.
- prd_strt  out  1  one-cycle pulse, registered, asserted in the cycle the counter is 0 while en=1.

## Operation
- Shared counter cnt, WIDTH bits, MAX = 2^WIDTH−1.
- Edge mode: 0,1,…,MAX,0,… with natural wrap; period = 2^WIDTH cycles.
- Center mode: up 0→MAX, then down MAX−1→1, then 0; period = 2·MAX cycles. A direction flag is held internally.
- Boundary cycle: the cycle in which next cnt = 0 (edge: cnt=MAX; center: cnt=1 counting down).
- Per channel: shadow_duty[ch] is loaded by wr when wr_ch=ch. active_duty[ch] is copied from shadow at each boundary cycle.
- A wr with wr_ch ≥ CHANNELS is ignored.
- mode is also sampled into active_mode only at the boundary, so a mode change never truncates a period.
- Compare: PWM_sig[ch] next = en & (cnt < active_duty[ch]).
  - duty=0 gives constant low.
  - duty=MAX in edge mode gives high for MAX of 2^WIDTH cycles.
  - In center mode the output is high for 2·duty−1 cycles per period when duty≥1, centred on cnt=0.
- en low: cnt ← 0, direction ← up, PWM_sig ← 0, prd_strt ← 0. Shadow registers keep their value and keep accepting writes.
- en low also copies shadow→active and mode→active_mode every cycle, so the first period after enable uses the current values.
- A wr in the boundary cycle updates shadow at the next edge. The previous shadow value is the one transferred; the new value lands one period later.

## Timing
- Reset values: cnt=0, direction=up, shadow_duty=0, active_duty=0, active_mode=0, PWM_sig=0, prd_strt=0.
- Output latency: PWM_sig reflects the compare of the cnt value from the previous cycle (1 cycle).
- Write-to-effect: shadow updates 1 cycle after wr. The active value updates at the next boundary edge. The output reflects it from the first cycle of the following period, +1 cycle latency.
- Rising en: the counter is 0 in the first en=1 cycle. prd_strt and PWM_sig respond 1 cycle later.
- Reset asserted mid-period: all state clears immediately (asynchronous). Operation restarts at cnt=0 after deassertion.

## Configuration
- PWM_SYNC_DUTY_EN defined: double-buffered behaviour as above.
- PWM_SYNC_DUTY_EN undefined:
  - No shadow stage; wr writes active_duty directly, and the new value affects the compare from the next cycle.
  - mode applies immediately.
  - Glitches and short pulses mid-period are permitted.

## Structure
- Package pwm_pkg:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t.
  - Default WIDTH and CHANNELS localparams.
- Sub-module pwm_chan: holds the shadow/active duty registers, the compare, and the output flop for one channel. It is instantiated CHANNELS times in a generate loop.
- The counter, direction flag, active_mode and prd_strt live in the top module.

## Test plan
- WIDTH=8, edge mode, write duty 64 on ch0, en=1 → PWM_sig[0] high 64 cycles, low 192, period 256; prd_strt pulses every 256 cycles.
- Duty 0 and 255 on ch0/ch1 → ch0 never high; ch1 low exactly 1 cycle per 256.
- Center mode, WIDTH=4, duty 5 → period 30 cycles, high 9 cycles centred on cnt=0.
- Write duty 200 mid-period, then 10 in the boundary cycle (define set) → current period unchanged, next period 200, following period 10. With the macro undefined, the change applies on the next cycle.
- Toggle mode mid-period → period completes in the old mode; the new mode starts at cnt=0.
- Reset asserted at cnt=100 with output high → PWM_sig=0 and prd_strt=0 immediately. Shadow cleared; restart yields constant low until a write. A wr_ch ≥ CHANNELS write is ignored.
